mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle data-memory access controller between the memory stage and a stalling backing data memory. It replaces the single-cycle data memory instance. It captures a load or store request, issues it to the backing memory with a busy/done handshake, and holds the pipeline with `stall` until the access completes. It then presents the load data to writeback for one cycle, and it flags unaligned addresses and timeouts on `err`.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles in WAIT before abort.
- `CNT_W`, 7: timeout counter width; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_rd`  in  1  load request from the memory stage.
- `req_wr`  in  1  store request from the memory stage.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data.
- `flush`  in  1  squash the current request (branch/jump redirect).
- `stall`  out  1  hold all upstream pipeline registers; combinational.
- `rsp_valid`  out  1  one-cycle pulse when an access completes.
- `rd_data`  out  16  load data, valid with `rsp_valid` on loads.
- `err`  out  1  one-cycle pulse: unaligned address or timeout.
- `mem_rd`  out  1  backing memory read strobe.
- `mem_wr`  out  1  backing memory write strobe.
- `mem_addr`  out  16  latched address.
- `mem_wdata`  out  16  latched store data.
- `mem_busy`  in  1  backing memory cannot accept a request this cycle.
- `mem_done`  in  1  backing memory completion pulse.
- `mem_rdata`  in  16  read data, valid with `mem_done`.

## Operation
- State machine states: IDLE, ISSUE, WAIT, DONE.
- A request is `req = req_rd | req_wr`. If both are high, the access is a write; no error is raised.
- IDLE:
  - `req & ~flush & ~req_addr[0]`: latch addr, wdata and type; go to ISSUE.
  - `req & ~flush & req_addr[0]`: no memory access. Go to DONE with an error flag set and `rd_data`=0.
  - `flush` or `~req`: stay in IDLE.
- ISSUE:
  - Drive `mem_rd` or `mem_wr` with the latched `mem_addr`/`mem_wdata`.
  - `~mem_busy`: the request is accepted; clear the counter and go to WAIT.
  - `mem_busy`: stay in ISSUE.
  - `flush` while not yet accepted: go to IDLE with no access.
- WAIT:
  - Strobes are low. The counter increments each cycle.
  - `mem_done`: register `mem_rdata` into `rd_data` (loads only; stores register 0) and go to DONE.
  - Counter reaches `TIMEOUT` without `mem_done`: set the error flag, `rd_data`=0, go to DONE.
  - `flush` in WAIT is ignored: an accepted access always completes.
- DONE:
  - `rsp_valid`=1 and `err`=error flag, for one cycle. The error flag then clears.
  - `stall`=0, so the pipeline advances past the completed request at the end of this cycle.
  - Always return to IDLE; the request still visible at the inputs this cycle is not re-accepted.
- A `mem_done` seen outside WAIT is ignored.
- `stall` = (IDLE & req & ~flush) | ISSUE | WAIT.

## Timing
- Reset (`rst` high at a clock edge):
  - State goes to IDLE; counter and error flag clear.
  - `rsp_valid`, `err`, `mem_rd`, `mem_wr` are 0.
  - `rd_data`, `mem_addr`, `mem_wdata` are 0x0000.
  - `stall` is then 0 unless a request is pending.
  - Reset mid-access abandons the access; a later `mem_done` is ignored.
- Cycle numbering: a request is first seen in IDLE at cycle 0.
  - Cycle 0: `stall`=1.
  - Cycle 1: ISSUE. The strobe is high; the request is accepted if `mem_busy`=0.
  - `mem_done` at cycle k ≥ 2 leads to DONE at cycle k+1 with `rsp_valid`=1 and `stall`=0.
  - Best case is 3 stall cycles (0–2), so the total latency is k+1 cycles.
- Each `mem_busy` cycle in ISSUE adds one cycle to the latency.
- Unaligned access: cycle 0 stalls; cycle 1 is DONE with `rsp_valid`=1 and `err`=1; no strobe is ever driven.
- Timeout: the counter starts at 0 on the first WAIT cycle. Abort after `TIMEOUT` WAIT cycles without `mem_done`; DONE follows on the next cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. A new request costs at least 4 cycles in total.

## Test plan
- Load: `req_rd`=1 at 0x0010 with `mem_busy`=0 and `mem_done` at cycle 2 with 0xBEEF -> `mem_rd`=1 only in cycle 1; `stall`=1 in cycles 0–2; cycle 3 has `rsp_valid`=1, `rd_data`=0xBEEF, `err`=0.
- Store with busy: `req_wr`=1, addr 0x0020, data 0x1234, `mem_busy`=1 in cycles 1–3 -> `mem_wr` held in cycles 1–4 with `mem_addr`=0x0020 and `mem_wdata`=0x1234; `rsp_valid` one cycle after `mem_done`.
- Unaligned: `req_rd` at 0x0013 -> no `mem_rd`/`mem_wr` ever; cycle 1 has `rsp_valid`=1, `err`=1, `rd_data`=0.
- Timeout: `TIMEOUT`=4 and `mem_done` never asserted -> `err`=1, `rd_data`=0 after 4 WAIT cycles; a late `mem_done` is ignored.
- Flush:
  - `flush` in ISSUE while `mem_busy`=1 -> IDLE, no acceptance, no `rsp_valid`.
  - `flush` in WAIT -> the access completes normally.
- Reset in WAIT: `rst` pulse -> all outputs return to reset values the next cycle; a subsequent `mem_done` produces no `rsp_valid`.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller: captures a load/store, runs the
// busy/done handshake with the backing memory and stalls the pipeline until done.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rsp_valid,
  output logic [15:0] rd_data,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err, r_is_wr;
  logic [15:0]      r_addr, r_wdata, r_rd_data;
  logic             w_take, w_timeout;

  assign w_take    = (req_rd | req_wr) & ~flush;
  // Last permitted WAIT cycle: counter started at 0 on the first one.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    rsp_valid = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall = w_take;
        if (w_take) w_next = req_addr[0] ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        stall  = 1'b1;
        mem_rd = ~r_is_wr;
        mem_wr = r_is_wr;
        // Acceptance wins over flush: once the strobe is taken the access runs.
        if (!mem_busy)  w_next = S_WAIT;
        else if (flush) w_next = S_IDLE;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_done || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        err       = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (req_addr[0]) begin
              r_err     <= 1'b1;
              r_rd_data <= '0;
            end else begin
              r_addr  <= req_addr;
              r_wdata <= req_wdata;
              r_is_wr <= req_wr;
            end
          end
        end
        S_ISSUE: if (!mem_busy) r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_done) begin
            r_rd_data <= r_is_wr ? 16'h0000 : mem_rdata;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_rd_data <= '0;
          end
        end
        S_DONE: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req_rd, req_wr, flush, mem_busy, mem_done;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  logic        stall, rsp_valid, err, mem_rd, mem_wr;
  logic [15:0] rd_data, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .rsp_valid(rsp_valid), .rd_data(rd_data), .err(err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding access described by what it is doing, not how.
  bit          m_issuing, m_waiting, m_resp, m_rerr, m_write;
  int          m_age;
  logic [15:0] m_addr = '0, m_wdata = '0, m_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_issuing = 0; m_waiting = 0; m_resp = 0; m_rerr = 0; m_write = 0;
      m_age = 0; m_addr = '0; m_wdata = '0; m_data = '0;
    end else if (m_resp) begin
      m_resp = 0; m_rerr = 0;
    end else if (m_issuing) begin
      if (!mem_busy) begin
        m_issuing = 0; m_waiting = 1; m_age = 0;
      end else if (flush) begin
        m_issuing = 0;
      end
    end else if (m_waiting) begin
      m_age++;
      if (mem_done) begin
        m_waiting = 0; m_resp = 1; m_rerr = 0;
        m_data = m_write ? 16'h0 : mem_rdata;
      end else if (m_age == TO) begin
        m_waiting = 0; m_resp = 1; m_rerr = 1; m_data = 16'h0;
      end
    end else if ((req_rd || req_wr) && !flush) begin
      if (req_addr[0]) begin
        m_resp = 1; m_rerr = 1; m_data = 16'h0;
      end else begin
        m_issuing = 1; m_write = req_wr; m_addr = req_addr; m_wdata = req_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit idle;
      idle = !(m_issuing || m_waiting || m_resp);
      chk("m_stall", {15'b0, stall},
          {15'b0, (idle && (req_rd || req_wr) && !flush) || m_issuing || m_waiting});
      chk("m_rsp_valid", {15'b0, rsp_valid}, {15'b0, m_resp});
      chk("m_err", {15'b0, err}, {15'b0, m_resp && m_rerr});
      chk("m_mem_rd", {15'b0, mem_rd}, {15'b0, m_issuing && !m_write});
      chk("m_mem_wr", {15'b0, mem_wr}, {15'b0, m_issuing && m_write});
      chk("m_rd_data", rd_data, m_data);
      chk("m_mem_addr", mem_addr, m_addr);
      chk("m_mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    req_rd = 0; req_wr = 0; req_addr = '0; req_wdata = '0; flush = 0;
    mem_busy = 0; mem_done = 0; mem_rdata = '0;
  endtask

  initial begin
    rst = 1; idle_in();
    step; chk_en = 1;
    @(negedge clk);
    chk("rst_stall", {15'b0, stall}, 16'd0);
    chk("rst_rsp", {15'b0, rsp_valid}, 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_rdata", rd_data, 16'h0000);
    step; rst = 0;

    // Aligned load, done in cycle 2
    req_rd = 1; req_addr = 16'h0010;
    @(negedge clk); chk("ld_c0_stall", {15'b0, stall}, 16'd1);
    chk("ld_c0_rd", {15'b0, mem_rd}, 16'd0);
    step; @(negedge clk);
    chk("ld_c1_rd", {15'b0, mem_rd}, 16'd1); chk("ld_c1_addr", mem_addr, 16'h0010);
    step; mem_done = 1; mem_rdata = 16'hBEEF; @(negedge clk);
    chk("ld_c2_stall", {15'b0, stall}, 16'd1); chk("ld_c2_rd", {15'b0, mem_rd}, 16'd0);
    step; mem_done = 0; @(negedge clk);
    chk("ld_c3_rsp", {15'b0, rsp_valid}, 16'd1); chk("ld_c3_data", rd_data, 16'hBEEF);
    chk("ld_c3_err", {15'b0, err}, 16'd0); chk("ld_c3_stall", {15'b0, stall}, 16'd0);
    step; idle_in(); @(negedge clk);
    chk("ld_c4_rsp", {15'b0, rsp_valid}, 16'd0);

    // Store with memory busy in cycles 1-3
    req_wr = 1; req_addr = 16'h0020; req_wdata = 16'h1234; mem_busy = 1;
    for (int c = 1; c <= 4; c++) begin
      step; if (c == 4) mem_busy = 0;
      @(negedge clk);
      chk("st_wr", {15'b0, mem_wr}, 16'd1);
      chk("st_addr", mem_addr, 16'h0020); chk("st_wdata", mem_wdata, 16'h1234);
    end
    step; mem_done = 1; mem_rdata = 16'h5555; @(negedge clk);
    chk("st_c5_wr", {15'b0, mem_wr}, 16'd0); chk("st_c5_rsp", {15'b0, rsp_valid}, 16'd0);
    step; mem_done = 0; @(negedge clk);
    chk("st_c6_rsp", {15'b0, rsp_valid}, 16'd1); chk("st_c6_data", rd_data, 16'h0000);
    step; idle_in();

    // Unaligned load
    req_rd = 1; req_addr = 16'h0013;
    @(negedge clk); chk("ua_c0_stall", {15'b0, stall}, 16'd1);
    step; @(negedge clk);
    chk("ua_c1_rsp", {15'b0, rsp_valid}, 16'd1); chk("ua_c1_err", {15'b0, err}, 16'd1);
    chk("ua_c1_data", rd_data, 16'h0000); chk("ua_c1_rd", {15'b0, mem_rd}, 16'd0);
    step; idle_in();

    // Timeout: WAIT in cycles 2..5, DONE in cycle 6
    req_rd = 1; req_addr = 16'h0040;
    step;
    for (int c = 2; c <= 5; c++) begin
      step; @(negedge clk);
      chk("to_wait_stall", {15'b0, stall}, 16'd1); chk("to_wait_rsp", {15'b0, rsp_valid}, 16'd0);
    end
    step; @(negedge clk);
    chk("to_rsp", {15'b0, rsp_valid}, 16'd1); chk("to_err", {15'b0, err}, 16'd1);
    chk("to_data", rd_data, 16'h0000);
    step; idle_in(); mem_done = 1; mem_rdata = 16'h7777;
    step; mem_done = 0; @(negedge clk);
    chk("to_late_rsp", {15'b0, rsp_valid}, 16'd0); chk("to_late_stall", {15'b0, stall}, 16'd0);

    // Flush in ISSUE while busy
    step; req_rd = 1; req_addr = 16'h0050; mem_busy = 1;
    step; flush = 1;
    step; idle_in();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("fi_rsp", {15'b0, rsp_valid}, 16'd0);
      chk("fi_rd", {15'b0, mem_rd}, 16'd0); step;
    end

    // Flush in WAIT is ignored
    req_rd = 1; req_addr = 16'h0060;
    step; step; flush = 1;
    step; flush = 0; mem_done = 1; mem_rdata = 16'hCAFE;
    step; mem_done = 0; @(negedge clk);
    chk("fw_rsp", {15'b0, rsp_valid}, 16'd1); chk("fw_data", rd_data, 16'hCAFE);
    step; idle_in();

    // Reset during WAIT
    req_rd = 1; req_addr = 16'h0070;
    step; step; rst = 1; req_rd = 0;
    step; rst = 0; mem_done = 1; mem_rdata = 16'h9999; @(negedge clk);
    chk("rw_addr", mem_addr, 16'h0000); chk("rw_data", rd_data, 16'h0000);
    chk("rw_stall", {15'b0, stall}, 16'd0);
    step; mem_done = 0; @(negedge clk);
    chk("rw_rsp", {15'b0, rsp_valid}, 16'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step;
      rst       = ($urandom_range(0, 199) == 0);
      req_rd    = ($urandom_range(0, 2) == 0);
      req_wr    = ($urandom_range(0, 2) == 0);
      req_addr  = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 7) == 0) req_addr[0] = 1'b1;
      req_wdata = 16'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      mem_busy  = ($urandom_range(0, 1) == 0);
      mem_done  = ($urandom_range(0, 4) == 0);
      mem_rdata = 16'($urandom);
    end
    step; idle_in(); step;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
